tdc_meas_seq: RTL and testbench
===============================

Name: tdc_meas_seq

Overview:
Measurement sequencer for the TDC wrapper. It holds the control CSR fields (pulse source, toggle mode, delay-line select) and drives them to the wrapper. On `start` it runs a burst of N launch/capture cycles: it fires or awaits a launch pulse, waits for the delay line to settle, then decodes the thermometer tap code. It accumulates sum/min/max of the decoded counts and returns one result over a valid/ready handshake. It sits between the user/TinyTapeout IO logic and the TDC datapath.

Parameters:
TAP_W, 32, delay-line tap (thermometer) width
SETTLE, 4, cycles from launch to sample (>=1)
TIMEOUT, 1023, max cycles to wait for external pulse in PG_IN mode
CNT_W, $clog2(TAP_W+1), decoded count width (derived)
SUM_W, 8+CNT_W, accumulator width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_pls_src  in  1  ctrl_pulse_src_t (PG_IN/PG_TOG)
cfg_tog  in  1  ctrl_tog_t (TOG_BYP/TOG_REG)
cfg_dl  in  2  ctrl_delay_line_t (MUX/ADD)
cfg_nsamp  in  8  samples per burst, 0 means 256
start  in  1  begin burst (single-cycle strobe)
ext_pls  in  1  external pulse, already synchronised to clk
tap_code  in  TAP_W  captured thermometer code from delay line
ctl_pls_src  out  1  registered CSR field to wrapper
ctl_tog  out  1  registered CSR field to wrapper
ctl_delay_line  out  2  registered CSR field to wrapper
launch_pls  out  1  one-cycle launch pulse (TOG_BYP)
launch_tog  out  1  launch level, toggles per launch (TOG_REG)
busy  out  1  burst in progress or result pending
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_sum  out  SUM_W  sum of decoded counts
res_min  out  CNT_W  minimum decoded count
res_max  out  CNT_W  maximum decoded count
res_bubble  out  1  at least one sample was non-thermometer
res_timeout  out  1  burst aborted on PG_IN timeout

Behaviour:
- Reset values:
  - ctl_pls_src=PG_IN, ctl_tog=TOG_BYP, ctl_delay_line=MUX, stored nsamp=1.
  - launch_pls=0, launch_tog=0, busy=0, res_valid=0, all res_* fields 0.
  - FSM in IDLE.
- Config writes:
  - cfg_we is honoured only in IDLE and ignored otherwise. Fields update on the next edge.
  - cfg_we and start in the same IDLE cycle: the write lands and the burst uses the new config.
  - cfg_dl value 2 or 3 is stored as written; it is not a defined ctrl_delay_line_t value and is treated as reserved.
- FSM states: IDLE -> FIRE -> SETTLE -> SAMPLE -> (FIRE | RESULT) -> IDLE.
- IDLE:
  - start=1 loads the sample counter from nsamp (0 becomes 256), clears sum/bubble/timeout, sets min to all-ones and max to 0, sets busy=1, and moves to FIRE.
  - start in any other state is ignored.
- FIRE with PG_TOG:
  - TOG_BYP: launch_pls=1 for exactly this one cycle.
  - TOG_REG: launch_tog inverts and launch_pls stays 0.
  - Next state is SETTLE.
- FIRE with PG_IN:
  - Wait for a rising edge on ext_pls (previous value registered; the edge register resets to 0); no launch outputs.
  - Edge seen -> SETTLE.
  - TIMEOUT cycles without an edge -> set timeout and go to RESULT.
- SETTLE: counts SETTLE cycles, then goes to SAMPLE. Sample edge = launch edge + SETTLE + 1.
- SAMPLE (one cycle):
  - count = number of consecutive 1s from bit 0 (0..TAP_W).
  - Any 1 above the first 0 sets bubble; count is still the leading-ones value.
  - sum += count; min/max updated; sample counter decremented.
  - Counter reaches 0 -> RESULT, else -> FIRE.
- RESULT:
  - res_valid=1; fields hold stable until res_valid && res_ready. On that edge go to IDLE, clear res_valid and busy.
  - Fields keep their last values after the handshake.
  - On timeout with zero samples taken: min=0, max=0, sum=0.
- SUM_W never overflows: 256*TAP_W fits by construction.
- Reset mid-burst: immediate return to reset values; any partial result is discarded.

Decomposition:
- Package tdc_wrapper_pkg gains:
  - typedef `tdc_seq_state_t` (IDLE, FIRE, SETTLE, SAMPLE, RESULT).
  - a packed `tdc_result_t` (sum/min/max/flags).
  - localparam defaults for SETTLE and TIMEOUT.
- The existing ctrl_pulse_src_t, ctrl_tog_t and ctrl_delay_line_t types are reused for the CSR fields.
- Sub-module `tdc_therm_decode`: purely combinational. Input TAP_W code; outputs CNT_W leading-ones count and a bubble flag. Verified standalone.

Test Plan:
- Reset, then read outputs -> ctl fields 0/0/MUX, busy=0, res_valid=0, launch_pls=0.
- Config PG_TOG/TOG_BYP, nsamp=4, SETTLE=4, tap_code=0x0000_00FF constant, start -> 4 launch_pls pulses 6 cycles apart; result sum=32, min=max=8, bubble=0.
- PG_TOG/TOG_REG, nsamp=3 -> launch_tog toggles 0->1->0->1, launch_pls never high; result valid.
- tap_code=0x0000_F00F for one sample of nsamp=2 (other 0x0000_0003) -> counts 4 and 2, sum=6, min=2, max=4, bubble=1.
- PG_IN, nsamp=2, no ext_pls for TIMEOUT cycles -> res_timeout=1, sum=0, min=max=0; a second run with edges at cycles 10 and 30 -> 2 samples, timeout=0.
- Hold res_ready=0 for 20 cycles with start/cfg_we pulses -> result held, start/cfg ignored; res_ready=1 -> IDLE. Assert rst_n mid-SETTLE -> all outputs at reset values.

Source files
------------

// File: rtl/tdc_wrapper_pkg.sv
// Shared types and defaults for the TDC wrapper and its measurement sequencer.
package tdc_wrapper_pkg;

   // CSR field encodings driven to the wrapper
   typedef enum logic {
      PG_IN  = 1'b0,
      PG_TOG = 1'b1
   } ctrl_pulse_src_t;

   typedef enum logic {
      TOG_BYP = 1'b0,
      TOG_REG = 1'b1
   } ctrl_tog_t;

   // Values 2 and 3 are reserved; the CSR still stores them as written
   typedef enum logic [1:0] {
      MUX = 2'd0,
      ADD = 2'd1
   } ctrl_delay_line_t;

   // Measurement sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FIRE   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_RESULT = 3'd4
   } tdc_seq_state_t;

   localparam int unsigned TDC_TAP_W_DEF   = 32;
   localparam int unsigned TDC_SETTLE_DEF  = 4;
   localparam int unsigned TDC_TIMEOUT_DEF = 1023;
   localparam int unsigned TDC_CNT_W_DEF   = $clog2(TDC_TAP_W_DEF + 1);
   localparam int unsigned TDC_SUM_W_DEF   = 8 + TDC_CNT_W_DEF;

   // Burst result as returned over the valid/ready handshake
   typedef struct packed {
      logic [TDC_SUM_W_DEF-1:0] sum;
      logic [TDC_CNT_W_DEF-1:0] min_cnt;
      logic [TDC_CNT_W_DEF-1:0] max_cnt;
      logic                     bubble;
      logic                     timeout;
   } tdc_result_t;

endpackage

// File: rtl/tdc_therm_decode.sv
// Thermometer decoder: leading-ones count from bit 0 plus a bubble flag for
// any 1 found above the first 0.
module tdc_therm_decode
   import tdc_wrapper_pkg::*;
#(
   parameter int unsigned TAP_W = TDC_TAP_W_DEF,
   parameter int unsigned CNT_W = $clog2(TAP_W + 1)
) (
   input  logic [TAP_W-1:0] code,
   output logic [CNT_W-1:0] cnt_c,
   output logic             bubble_c
);

   logic run;

   // Scan upward from bit 0; the run of ones ends at the first 0
   always_comb begin
      cnt_c    = '0;
      bubble_c = 1'b0;
      run      = 1'b1;
      for (int i = 0; i < TAP_W; i++) begin
         if (run) begin
            if (code[i]) cnt_c = CNT_W'(i + 1);
            else         run   = 1'b0;
         end else if (code[i]) begin
            bubble_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tdc_meas_seq.sv
// TDC measurement sequencer: holds the control CSR, runs bursts of
// launch/settle/sample cycles and returns sum/min/max of decoded tap counts.
module tdc_meas_seq
   import tdc_wrapper_pkg::*;
#(
   parameter int unsigned TAP_W   = TDC_TAP_W_DEF,
   parameter int unsigned SETTLE  = TDC_SETTLE_DEF,
   parameter int unsigned TIMEOUT = TDC_TIMEOUT_DEF,
   parameter int unsigned CNT_W   = $clog2(TAP_W + 1),
   parameter int unsigned SUM_W   = 8 + CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic             cfg_pls_src,
   input  logic             cfg_tog,
   input  logic [1:0]       cfg_dl,
   input  logic [7:0]       cfg_nsamp,
   input  logic             start,
   input  logic             ext_pls,
   input  logic [TAP_W-1:0] tap_code,
   output logic             ctl_pls_src,
   output logic             ctl_tog,
   output logic [1:0]       ctl_delay_line,
   output logic             launch_pls,
   output logic             launch_tog,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SUM_W-1:0] res_sum,
   output logic [CNT_W-1:0] res_min,
   output logic [CNT_W-1:0] res_max,
   output logic             res_bubble,
   output logic             res_timeout
);

   localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned LEFT_W = 9;
   localparam int unsigned RS_W   = TDC_SUM_W_DEF;
   localparam int unsigned RC_W   = TDC_CNT_W_DEF;

   tdc_seq_state_t   state_q, state_d;
   ctrl_pulse_src_t  src_q, src_d;
   ctrl_tog_t        tog_q, tog_d;
   logic [1:0]       dl_q, dl_d;
   logic [7:0]       nsamp_q, nsamp_d;
   logic             ext_prev_q;
   logic             launch_pls_q, launch_pls_d;
   logic             launch_tog_q, launch_tog_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [LEFT_W-1:0] left_q, left_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [TO_W-1:0]  wait_q, wait_d;
   logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
   logic [CNT_W-1:0] acc_min_q, acc_min_d;
   logic [CNT_W-1:0] acc_max_q, acc_max_d;
   logic             acc_bub_q, acc_bub_d;
   logic             acc_to_q, acc_to_d;
   logic             taken_q, taken_d;
   tdc_result_t      res_q, res_d;
   logic [CNT_W-1:0] dec_cnt;
   logic             dec_bub;
   logic             ext_rise;

   tdc_therm_decode #(
      .TAP_W (TAP_W),
      .CNT_W (CNT_W)
   ) u_decode (
      .code     (tap_code),
      .cnt_c    (dec_cnt),
      .bubble_c (dec_bub)
   );

   assign ext_rise = ext_pls & ~ext_prev_q;

   // Next-state, CSR, accumulator and launch/result output logic
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      tog_d        = tog_q;
      dl_d         = dl_q;
      nsamp_d      = nsamp_q;
      launch_pls_d = 1'b0;
      launch_tog_d = launch_tog_q;
      busy_d       = busy_q;
      valid_d      = valid_q;
      left_d       = left_q;
      settle_d     = settle_q;
      wait_d       = wait_q;
      acc_sum_d    = acc_sum_q;
      acc_min_d    = acc_min_q;
      acc_max_d    = acc_max_q;
      acc_bub_d    = acc_bub_q;
      acc_to_d     = acc_to_q;
      taken_d      = taken_q;
      res_d        = res_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_we) begin
               src_d   = ctrl_pulse_src_t'(cfg_pls_src);
               tog_d   = ctrl_tog_t'(cfg_tog);
               dl_d    = cfg_dl;
               nsamp_d = cfg_nsamp;
            end
            if (start) begin
               left_d    = (nsamp_d == 8'd0) ? LEFT_W'(256) : LEFT_W'(nsamp_d);
               acc_sum_d = '0;
               acc_min_d = '1;
               acc_max_d = '0;
               acc_bub_d = 1'b0;
               acc_to_d  = 1'b0;
               taken_d   = 1'b0;
               wait_d    = '0;
               busy_d    = 1'b1;
               state_d   = ST_FIRE;
            end
         end
         ST_FIRE: begin
            if (src_q == PG_TOG) begin
               settle_d = '0;
               state_d  = ST_SETTLE;
            end else if (ext_rise) begin
               settle_d = '0;
               wait_d   = '0;
               state_d  = ST_SETTLE;
            end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
               wait_d   = '0;
               acc_to_d = 1'b1;
               state_d  = ST_RESULT;
            end else begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         ST_SETTLE: begin
            if (settle_q == SET_W'(SETTLE - 1)) state_d = ST_SAMPLE;
            else                                settle_d = settle_q + SET_W'(1);
         end
         ST_SAMPLE: begin
            acc_sum_d = acc_sum_q + SUM_W'(dec_cnt);
            if (dec_cnt < acc_min_q) acc_min_d = dec_cnt;
            if (dec_cnt > acc_max_q) acc_max_d = dec_cnt;
            acc_bub_d = acc_bub_q | dec_bub;
            taken_d   = 1'b1;
            left_d    = left_q - LEFT_W'(1);
            if (left_q == LEFT_W'(1)) begin
               state_d = ST_RESULT;
            end else begin
               wait_d  = '0;
               state_d = ST_FIRE;
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Internal launch fires on each entry into FIRE
      if (state_d == ST_FIRE && state_q != ST_FIRE && src_d == PG_TOG) begin
         if (tog_d == TOG_BYP) launch_pls_d = 1'b1;
         else                  launch_tog_d = ~launch_tog_q;
      end

      // Freeze the result on entry into RESULT; empty bursts report zeros
      if (state_d == ST_RESULT && state_q != ST_RESULT) begin
         valid_d       = 1'b1;
         res_d.sum     = RS_W'(acc_sum_d);
         res_d.min_cnt = taken_d ? RC_W'(acc_min_d) : '0;
         res_d.max_cnt = RC_W'(acc_max_d);
         res_d.bubble  = acc_bub_d;
         res_d.timeout = acc_to_d;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         src_q        <= PG_IN;
         tog_q        <= TOG_BYP;
         dl_q         <= MUX;
         nsamp_q      <= 8'd1;
         ext_prev_q   <= 1'b0;
         launch_pls_q <= 1'b0;
         launch_tog_q <= 1'b0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         left_q       <= '0;
         settle_q     <= '0;
         wait_q       <= '0;
         acc_sum_q    <= '0;
         acc_min_q    <= '0;
         acc_max_q    <= '0;
         acc_bub_q    <= 1'b0;
         acc_to_q     <= 1'b0;
         taken_q      <= 1'b0;
         res_q        <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         tog_q        <= tog_d;
         dl_q         <= dl_d;
         nsamp_q      <= nsamp_d;
         ext_prev_q   <= ext_pls;
         launch_pls_q <= launch_pls_d;
         launch_tog_q <= launch_tog_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         left_q       <= left_d;
         settle_q     <= settle_d;
         wait_q       <= wait_d;
         acc_sum_q    <= acc_sum_d;
         acc_min_q    <= acc_min_d;
         acc_max_q    <= acc_max_d;
         acc_bub_q    <= acc_bub_d;
         acc_to_q     <= acc_to_d;
         taken_q      <= taken_d;
         res_q        <= res_d;
      end
   end

   assign ctl_pls_src    = src_q;
   assign ctl_tog        = tog_q;
   assign ctl_delay_line = dl_q;
   assign launch_pls     = launch_pls_q;
   assign launch_tog     = launch_tog_q;
   assign busy           = busy_q;
   assign res_valid      = valid_q;
   assign res_sum        = SUM_W'(res_q.sum);
   assign res_min        = CNT_W'(res_q.min_cnt);
   assign res_max        = CNT_W'(res_q.max_cnt);
   assign res_bubble     = res_q.bubble;
   assign res_timeout    = res_q.timeout;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Bench for tdc_meas_seq: directed table, corner sequences and random bursts
// checked against a count-based reference model.
module tb_tdc_meas_seq;
   import tdc_wrapper_pkg::*;

   localparam int unsigned TAP_W   = 32;
   localparam int unsigned SETTLE  = 4;
   localparam int unsigned TIMEOUT = 1023;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned SUM_W   = 14;

   logic             clk, rst_n;
   logic             cfg_we, cfg_pls_src, cfg_tog;
   logic [1:0]       cfg_dl;
   logic [7:0]       cfg_nsamp;
   logic             start, ext_pls, res_ready;
   logic [TAP_W-1:0] tap_code;
   logic             ctl_pls_src, ctl_tog, launch_pls, launch_tog, busy, res_valid;
   logic [1:0]       ctl_delay_line;
   logic [SUM_W-1:0] res_sum;
   logic [CNT_W-1:0] res_min, res_max;
   logic             res_bubble, res_timeout;

   int n_chk = 0;
   int n_pass = 0;
   logic [31:0] tq[$];

   tdc_meas_seq #(.TAP_W(TAP_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pls_src(cfg_pls_src),
      .cfg_tog(cfg_tog), .cfg_dl(cfg_dl), .cfg_nsamp(cfg_nsamp), .start(start),
      .ext_pls(ext_pls), .tap_code(tap_code), .ctl_pls_src(ctl_pls_src),
      .ctl_tog(ctl_tog), .ctl_delay_line(ctl_delay_line), .launch_pls(launch_pls),
      .launch_tog(launch_tog), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_sum(res_sum), .res_min(res_min), .res_max(res_max),
      .res_bubble(res_bubble), .res_timeout(res_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Leading-ones count: lowest set bit of (code+1) sits at index count
   function automatic int mdl_cnt(input logic [31:0] c);
      logic [32:0] t;
      t = {1'b0, c} + 33'd1;
      return $countones((t & (~t + 33'd1)) - 33'd1);
   endfunction

   function automatic bit mdl_bub(input logic [31:0] c);
      logic [32:0] w;
      w = {1'b0, c} >> mdl_cnt(c);
      return w != 33'd0;
   endfunction

   function automatic logic [31:0] gen_tap();
      logic [32:0] m;
      logic [31:0] v;
      m = (33'd1 << $urandom_range(0, 32)) - 33'd1;
      v = m[31:0];
      if ($urandom_range(0, 3) == 0) v = v | $urandom();
      return v;
   endfunction

   function automatic logic [31:0] pick_tap(input int sel, input logic [31:0] ctap, input int n);
      if (sel == 1) return gen_tap();
      if (sel == 2) return (n == 1) ? 32'h0000_F00F : 32'h0000_0003;
      return ctap;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_ctl_src"}, ctl_pls_src, 0);
      chk({tag, "_ctl_tog"}, ctl_tog, 0);
      chk({tag, "_ctl_dl"}, ctl_delay_line, 0);
      chk({tag, "_launch_pls"}, launch_pls, 0);
      chk({tag, "_launch_tog"}, launch_tog, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_res"}, {res_sum, res_min, res_max, res_bubble, res_timeout}, 0);
   endtask

   // One burst: optional config write with start, launch/pulse tracking,
   // model comparison, optional result hold, then handshake.
   task automatic run_burst(input bit wr_cfg, input logic src, input logic tog,
         input logic [1:0] dl, input logic [7:0] ns, input int tap_sel,
         input logic [31:0] ctap, input int ext_first, input int ext_gap,
         input int hold, input string tag);
      int cyc, nl, last_l, bad_sp, wrong, exp_n, nxt, e_sum, e_min, e_max, unstable;
      logic prev_tog, e_bub, e_to, got;
      logic [31:0] tp;
      exp_n = (ns == 8'd0) ? 256 : int'(ns);
      tq.delete();
      nl = 0; last_l = 0; bad_sp = 0; wrong = 0; cyc = 0; got = 1'b0; nxt = ext_first;
      @(negedge clk);
      if (wr_cfg) begin
         cfg_we = 1'b1; cfg_pls_src = src; cfg_tog = tog; cfg_dl = dl; cfg_nsamp = ns;
      end
      start = 1'b1;
      prev_tog = launch_tog;
      while (!got && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         cfg_we = 1'b0; start = 1'b0; ext_pls = 1'b0;
         if (src == PG_TOG) begin
            if ((tog == TOG_REG && launch_pls) || (tog == TOG_BYP && launch_tog !== prev_tog))
               wrong++;
            if (launch_pls || launch_tog !== prev_tog) begin
               if (nl > 0 && cyc - last_l != int'(SETTLE) + 2) bad_sp++;
               last_l = cyc; nl++;
               tp = pick_tap(tap_sel, ctap, nl); tap_code = tp; tq.push_back(tp);
            end
         end else begin
            if (launch_pls || launch_tog !== prev_tog) wrong++;
            if (ext_gap > 0 && nl < exp_n && cyc == nxt) begin
               ext_pls = 1'b1; nl++; nxt += ext_gap;
               tp = pick_tap(tap_sel, ctap, nl); tap_code = tp; tq.push_back(tp);
            end
         end
         prev_tog = launch_tog;
         if (res_valid) got = 1'b1;
      end
      ext_pls = 1'b0;
      chk({tag, "_valid"}, got, 1);
      chk({tag, "_wrong_launch"}, wrong, 0);
      if (src == PG_TOG) begin
         chk({tag, "_launches"}, nl, exp_n);
         chk({tag, "_spacing"}, bad_sp, 0);
         chk({tag, "_latency"}, cyc, (int'(SETTLE) + 2) * exp_n + 1);
      end else if (ext_gap == 0) begin
         chk({tag, "_to_latency"}, cyc, int'(TIMEOUT) + 1);
      end
      e_sum = 0; e_min = 1000; e_max = 0; e_bub = 1'b0;
      foreach (tq[i]) begin
         e_sum += mdl_cnt(tq[i]);
         if (mdl_cnt(tq[i]) < e_min) e_min = mdl_cnt(tq[i]);
         if (mdl_cnt(tq[i]) > e_max) e_max = mdl_cnt(tq[i]);
         e_bub |= mdl_bub(tq[i]);
      end
      if (tq.size() == 0) e_min = 0;
      e_to = (src == PG_IN) && (nl < exp_n);
      chk({tag, "_sum"}, res_sum, e_sum);
      chk({tag, "_min"}, res_min, e_min);
      chk({tag, "_max"}, res_max, e_max);
      chk({tag, "_bubble"}, res_bubble, e_bub);
      chk({tag, "_timeout"}, res_timeout, e_to);
      chk({tag, "_busy"}, busy, 1);
      if (wr_cfg) chk({tag, "_ctl_dl"}, ctl_delay_line, dl);
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         start = 1'b1; cfg_we = 1'b1; cfg_pls_src = ~src; cfg_tog = ~tog;
         cfg_dl = ~dl; cfg_nsamp = 8'd9;
         @(negedge clk);
         if (res_valid !== 1'b1 || res_sum !== SUM_W'(e_sum) || busy !== 1'b1) unstable++;
      end
      if (hold > 0) begin
         chk({tag, "_hold_stable"}, unstable, 0);
         chk({tag, "_hold_cfg"}, {ctl_pls_src, ctl_tog, ctl_delay_line}, {src, tog, dl});
      end
      start = 1'b0; cfg_we = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_post_valid"}, res_valid, 0);
      chk({tag, "_post_busy"}, busy, 0);
      chk({tag, "_post_sum"}, res_sum, e_sum);
   endtask

   typedef struct {
      logic        src;
      logic        tog;
      logic [7:0]  ns;
      logic [31:0] tap;
      int          e_sum;
      int          e_min;
      int          e_max;
      logic        e_bub;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{PG_TOG, TOG_BYP, 8'd4, 32'h0000_00FF, 32, 8, 8, 1'b0};
      tbl[1] = '{PG_TOG, TOG_REG, 8'd3, 32'hFFFF_FFFF, 96, 32, 32, 1'b0};
      tbl[2] = '{PG_TOG, TOG_BYP, 8'd1, 32'h0000_0000, 0, 0, 0, 1'b0};
      tbl[3] = '{PG_TOG, TOG_REG, 8'd2, 32'hFFFF_FFFE, 0, 0, 0, 1'b1};
      tbl[4] = '{PG_TOG, TOG_REG, 8'd0, 32'h0000_0007, 768, 3, 3, 1'b0};
      tbl[5] = '{PG_TOG, TOG_BYP, 8'd1, 32'h8000_0000, 0, 0, 0, 1'b1};

      rst_n = 1'b0; cfg_we = 1'b0; cfg_pls_src = 1'b0; cfg_tog = 1'b0; cfg_dl = 2'd0;
      cfg_nsamp = 8'd0; start = 1'b0; ext_pls = 1'b0; res_ready = 1'b0; tap_code = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("reset");

      // Stored defaults after reset: external pulse source, one sample
      run_burst(1'b0, PG_IN, TOG_BYP, 2'd0, 8'd1, 0, 32'h0000_01FF, 5, 10, 0, "dflt");

      for (int i = 0; i < 6; i++) begin
         run_burst(1'b1, tbl[i].src, tbl[i].tog, 2'(i % 2), tbl[i].ns, 0, tbl[i].tap,
                   0, 0, 0, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_exp_sum", i), res_sum, tbl[i].e_sum);
         chk($sformatf("tbl%0d_exp_min", i), res_min, tbl[i].e_min);
         chk($sformatf("tbl%0d_exp_max", i), res_max, tbl[i].e_max);
         chk($sformatf("tbl%0d_exp_bub", i), res_bubble, tbl[i].e_bub);
      end

      // Mixed thermometer and bubbled codes within one burst
      run_burst(1'b1, PG_TOG, TOG_BYP, 2'd1, 8'd2, 2, 32'h0, 0, 0, 0, "mixed");
      chk("mixed_exp", {res_sum, res_min, res_max, res_bubble},
          {SUM_W'(6), CNT_W'(2), CNT_W'(4), 1'b1});

      // External pulses: none at all, then two edges
      run_burst(1'b1, PG_IN, TOG_BYP, 2'd0, 8'd2, 0, 32'h0000_00FF, 0, 0, 0, "tmo");
      chk("tmo_exp", {res_sum, res_min, res_max, res_timeout}, {SUM_W'(0), CNT_W'(0), CNT_W'(0), 1'b1});
      run_burst(1'b1, PG_IN, TOG_REG, 2'd0, 8'd2, 0, 32'h0000_003F, 10, 20, 0, "ext2");
      chk("ext2_exp", {res_sum, res_timeout}, {SUM_W'(12), 1'b0});

      // Reserved delay-line code stored as written
      run_burst(1'b1, PG_TOG, TOG_BYP, 2'd2, 8'd1, 0, 32'h0000_000F, 0, 0, 0, "rsvd");

      // Result held under back-pressure with start/config activity
      run_burst(1'b1, PG_TOG, TOG_BYP, 2'd1, 8'd2, 0, 32'h0000_000F, 0, 0, 20, "hold");

      // Reset in the middle of SETTLE
      @(negedge clk);
      cfg_we = 1'b1; cfg_pls_src = PG_TOG; cfg_tog = TOG_BYP; cfg_dl = 2'd1; cfg_nsamp = 8'd4;
      start = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0;
      chk("mid_launch", launch_pls, 1);
      repeat (2) @(negedge clk);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_reset("mid_after");

      // Random bursts against the model
      for (int i = 0; i < 16; i++) begin
         logic s;
         s = ($urandom_range(0, 3) != 0) ? PG_TOG : PG_IN;
         run_burst(1'b1, s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   (s == PG_TOG) ? 8'($urandom_range(1, 6)) : 8'($urandom_range(1, 3)),
                   1, 32'h0, $urandom_range(2, 8), $urandom_range(8, 16),
                   $urandom_range(0, 3), $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
